// File: rtl/gc_conf_sequencer_pkg.sv
// Shared global-controller definitions: configuration select ids, sequencer
// state encoding and error codes.
package gc_conf_sequencer_pkg;

    localparam logic [2:0] GC_SEL_IDLE   = 3'b000;
    localparam logic [2:0] GC_SEL_STRIDE = 3'b011;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_WAIT_ACK,
        ST_DONE,
        ST_ERROR
    } gc_state_e;

    typedef enum logic [1:0] {
        ERR_NONE      = 2'b00,
        ERR_TIMEOUT   = 2'b01,
        ERR_ACKED     = 2'b10,
        ERR_EARLY_ACK = 2'b11
    } gc_err_e;

    // Words in a k x k stride matrix; an empty mask still loads one word.
    function automatic int unsigned gc_matrix_words(input int unsigned k);
        return (k == 0) ? 1 : k * k;
    endfunction

endpackage

// File: rtl/gc_conf_fifo.sv
// Small synchronous FIFO buffering loader words ahead of the configuration bus.
// Flush has priority over push and pop in the same cycle.
module gc_conf_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_data,
    output logic             o_full,
    output logic             o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_cnt;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_cnt == (AW+1)'(DEPTH));
    assign o_empty   = (r_cnt == '0);
    assign o_data    = r_mem[r_rd_ptr];
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (w_do_push && !i_flush) r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_cnt    <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_cnt <= r_cnt + {{AW{1'b0}}, w_do_push} - {{AW{1'b0}}, w_do_pop};
        end
    end

endmodule

// File: rtl/gc_conf_sequencer.sv
// Streams stride-matrix words from the loader FIFO onto conf_bus/sel, counts
// them against the active dimension and waits for the target's acknowledge.
module gc_conf_sequencer
    import gc_conf_sequencer_pkg::*;
#(
    parameter int                      DIMENSION            = 3,
    parameter int                      MATRIX_ELEMENT_WIDTH = 8,
    parameter int                      SELECT_WIDTH         = 3,
    parameter logic [SELECT_WIDTH-1:0] TARGET_SEL           = SELECT_WIDTH'(GC_SEL_STRIDE),
    parameter logic [SELECT_WIDTH-1:0] IDLE_SEL             = SELECT_WIDTH'(GC_SEL_IDLE),
    parameter int                      FIFO_DEPTH           = 4,
    parameter int                      ACK_TIMEOUT          = 16,
    localparam int                     CW                   = $clog2(DIMENSION*DIMENSION+1),
    localparam int                     TW                   = $clog2(ACK_TIMEOUT+1)
) (
    input  logic                            i_conf_clk,
    input  logic                            i_reset,
    input  logic                            i_start,
    input  logic [DIMENSION-1:0]            i_output_selector,
    input  logic [MATRIX_ELEMENT_WIDTH-1:0] i_in_data,
    input  logic                            i_in_valid,
    output logic                            o_in_ready,
    output logic [MATRIX_ELEMENT_WIDTH-1:0] o_conf_bus,
    output logic [SELECT_WIDTH-1:0]         o_sel,
    input  logic                            i_conf_ack,
    output logic                            o_busy,
    output logic                            o_done,
    output logic                            o_error,
    output logic [1:0]                      o_error_code,
    output logic [CW-1:0]                   o_word_count
);

    gc_state_e                       r_state;
    logic [DIMENSION-1:0]            r_mask;
    logic [CW-1:0]                   r_cnt;
    logic [TW-1:0]                   r_timer;
    logic [SELECT_WIDTH-1:0]         r_sel;
    logic [MATRIX_ELEMENT_WIDTH-1:0] r_bus;
    logic                            r_busy;
    logic                            r_done;
    logic                            r_error;
    logic [1:0]                      r_code;

    logic [MATRIX_ELEMENT_WIDTH-1:0] w_head;
    logic                            w_full;
    logic                            w_empty;
    logic                            w_push;
    logic                            w_issue;
    logic                            w_flush;
    logic                            w_timeout;
    logic [CW-1:0]                   w_n;

    // Only the contiguous run of ones from bit 0 counts as active dimensions.
    function automatic logic [CW-1:0] words_for(input logic [DIMENSION-1:0] mask);
        int unsigned k;
        logic        run;
        k   = 0;
        run = 1'b1;
        for (int i = 0; i < DIMENSION; i++) begin
            run = run & mask[i];
            if (run) k = k + 1;
        end
        return CW'(gc_matrix_words(k));
    endfunction

    assign w_n       = words_for(r_mask);
    assign w_timeout = (r_timer == TW'(ACK_TIMEOUT-1));
    assign w_issue   = (r_state == ST_LOAD) && !i_conf_ack && !w_empty;
    assign w_push    = i_in_valid && o_in_ready;
    assign w_flush   = ((r_state == ST_IDLE) && i_start && i_conf_ack)
                    || ((r_state == ST_LOAD) && i_conf_ack)
                    || ((r_state == ST_WAIT_ACK) && !i_conf_ack && w_timeout);

    assign o_in_ready   = i_reset && !w_full && (r_state != ST_ERROR);
    assign o_conf_bus   = r_bus;
    assign o_sel        = r_sel;
    assign o_busy       = r_busy;
    assign o_done       = r_done;
    assign o_error      = r_error;
    assign o_error_code = r_code;
    assign o_word_count = r_cnt;

    gc_conf_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MATRIX_ELEMENT_WIDTH)
    ) u_fifo (
        .i_clk   (i_conf_clk),
        .i_rst_n (i_reset),
        .i_push  (w_push),
        .i_data  (i_in_data),
        .i_pop   (w_issue),
        .i_flush (w_flush),
        .o_data  (w_head),
        .o_full  (w_full),
        .o_empty (w_empty)
    );

    always_ff @(posedge i_conf_clk or negedge i_reset) begin
        if (!i_reset) begin
            r_state <= ST_IDLE;
            r_mask  <= '0;
            r_cnt   <= '0;
            r_timer <= '0;
            r_sel   <= IDLE_SEL;
            r_bus   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_error <= 1'b0;
            r_code  <= ERR_NONE;
        end else begin
            r_done <= 1'b0;
            r_sel  <= IDLE_SEL;
            case (r_state)
                ST_IDLE, ST_ERROR: begin
                    if (i_start) begin
                        r_mask <= i_output_selector;
                        r_cnt  <= '0;
                        if (i_conf_ack) begin
                            // Target still holding a stale ack: refuse to load.
                            r_state <= ST_ERROR;
                            r_error <= 1'b1;
                            r_code  <= ERR_ACKED;
                        end else begin
                            r_state <= ST_LOAD;
                            r_busy  <= 1'b1;
                            r_error <= 1'b0;
                            r_code  <= ERR_NONE;
                        end
                    end
                end
                ST_LOAD: begin
                    if (i_conf_ack) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_code  <= ERR_EARLY_ACK;
                    end else if (w_issue) begin
                        r_sel <= TARGET_SEL;
                        r_bus <= w_head;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt + 1'b1 == w_n) begin
                            r_state <= ST_WAIT_ACK;
                            r_timer <= '0;
                        end
                    end
                end
                ST_WAIT_ACK: begin
                    if (i_conf_ack) begin
                        r_state <= ST_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end else if (w_timeout) begin
                        r_state <= ST_ERROR;
                        r_busy  <= 1'b0;
                        r_error <= 1'b1;
                        r_code  <= ERR_TIMEOUT;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end
                ST_DONE: r_state <= ST_IDLE;
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/gc_conf_sequencer.md
Name: gc_conf_sequencer

Overview:
- Global-controller configuration sequencer that streams stride-matrix words into the stride selector over the shared conf_bus/sel configuration interface.
- Buffers words from the upstream loader in a small FIFO, asserts the target select id only on cycles carrying valid data, and counts words against the active dimension.
- Waits for the target's conf_ack and reports done or error with a watchdog.

Parameters:
- DIMENSION, 3, maximum loop-nest dimension (stride matrix is DIMENSION x DIMENSION)
- MATRIX_ELEMENT_WIDTH, 8, width of one stride element / conf_bus
- SELECT_WIDTH, 3, width of sel
- TARGET_SEL, 3'b011, select id of the stride selector
- IDLE_SEL, 3'b000, select id driven when no word is issued
- FIFO_DEPTH, 4, input buffer entries (power of two, >=2)
- ACK_TIMEOUT, 16, cycles allowed between last word and conf_ack

Ports:
- conf_clk  in  1  configuration clock; all state on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; begins a load, sampled only in IDLE or ERROR
- output_selector  in  DIMENSION  active-dimension mask, latched on accepted start
- in_data  in  MATRIX_ELEMENT_WIDTH  stride word, column-major order (row fastest)
- in_valid  in  1  in_data valid
- in_ready  out  1  FIFO not full and state != ERROR
- conf_bus  out  MATRIX_ELEMENT_WIDTH  word to target
- sel  out  SELECT_WIDTH  TARGET_SEL on issue cycles, else IDLE_SEL
- conf_ack  in  1  target's configuration acknowledge
- busy  out  1  state is LOAD or WAIT_ACK
- done  out  1  one-cycle pulse on successful completion
- error  out  1  high in ERROR
- error_code  out  2  01 timeout, 10 target already acked at start, 11 premature ack
- word_count  out  $clog2(DIMENSION*DIMENSION+1)  words issued in current load

Behaviour:
- Reset (reset=0, async): state IDLE, FIFO empty, in_ready=0 during reset and 1 after, sel=IDLE_SEL, conf_bus=0, busy=0, done=0, error=0, error_code=00, word_count=0, timer=0.
- Word count: k = number of contiguous ones in output_selector starting at bit 0. N = max(k,1)^2, so k=0 yields N=1. Compute N as a combinational constant from the latched mask.
- FIFO: push on in_valid&&in_ready in IDLE, LOAD, WAIT_ACK and DONE, which allows preload before start. Pop only on issue cycles. Simultaneous push/pop when full is not permitted because in_ready=0 when full; when non-full, both take effect. Words beyond N stay buffered for the next load.
- IDLE: on start, latch mask, clear word_count, then:
  - if conf_ack=1, go to ERROR with code 10;
  - otherwise go to LOAD.
- LOAD: each cycle the FIFO is non-empty, drive sel=TARGET_SEL and conf_bus=FIFO head (registered outputs from the head, zero extra latency), pop, and word_count++. When the FIFO is empty, sel=IDLE_SEL and conf_bus holds its last value.
  - When the issue brings word_count to N, go to WAIT_ACK and clear the timer.
  - If conf_ack=1 in LOAD before N words are issued, go to ERROR with code 11.
- WAIT_ACK: sel=IDLE_SEL; timer++ each cycle.
  - conf_ack=1 goes to DONE; the target's ack normally rises the cycle after the last issue.
  - timer==ACK_TIMEOUT-1 without ack goes to ERROR with code 01.
  - If ack and timeout occur in the same cycle, ack wins.
- DONE: done=1 for exactly one cycle, then IDLE. start in DONE is ignored.
- ERROR: error=1 and code held; FIFO flushed on entry; in_ready=0.
  - start (with conf_ack=0) clears error/code and enters LOAD.
  - start with conf_ack=1 stays in ERROR with code 10.
- start outside IDLE/ERROR is ignored.
- Reset mid-load returns everything to reset values immediately; buffered words are lost.

Decomposition:
- Shared gc package: select-id constants (TARGET_SEL for stride selector, IDLE_SEL), state encoding, error_code constants.
- One natural sub-module: gc_conf_fifo, a synchronous FIFO with depth/width parameters, push/pop/full/empty/flush, and asynchronous active-low reset.

Test Plan:
- output_selector=3'b111, push 9 words 0x01..0x09, then start -> sel=3'b011 for 9 consecutive cycles with conf_bus 0x01..0x09, word_count=9, done pulse after ack, busy low after.
- output_selector=3'b011, words fed with 1-cycle gaps -> sel=3'b011 only on data cycles (4 total), IDLE_SEL in gaps, done after ack.
- output_selector=3'b000 -> exactly 1 word issued, done; output_selector=3'b101 -> N=1.
- conf_ack held 0 after the last word -> error=1, code 01 exactly ACK_TIMEOUT=16 cycles after entering WAIT_ACK; FIFO flushed, in_ready=0; a new start recovers.
- conf_ack=1 at start -> ERROR code 10, no sel pulse. conf_ack forced high after 2 of 4 words -> code 11.
- Assert reset low during word 5 of 9 -> all outputs at reset values asynchronously; the next start reloads cleanly.
